// File: rtl/acc_sequencer.sv
// Accumulator control sequencer: LOAD / EXEC / STORE / DONE per request, with ALU flag capture.
// Optional ACC_SEQ_B2B_EN: accept a new request in DONE so back-to-back requests have no IDLE gap.
module acc_sequencer #(
   parameter int                      OPCODE_WIDTH = 5,
   parameter int                      STATUS_WIDTH = 4,
   parameter logic [OPCODE_WIDTH-1:0] LD_OPCODE    = '0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic [OPCODE_WIDTH-1:0] op_i,
   input  logic                    reload_i,
   input  logic                    store_i,
   input  logic [STATUS_WIDTH-1:0] alu_status_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    src_oe_o,
   output logic                    acc_cs_o,
   output logic                    acc_we_o,
   output logic                    acc_oe_o,
   output logic                    acc_opcode_le_o,
   output logic [OPCODE_WIDTH-1:0] acc_opcode_o,
   output logic [STATUS_WIDTH-1:0] flags_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [OPCODE_WIDTH-1:0] op_q, op_d;
   logic                    reload_q, reload_d;
   logic                    store_q, store_d;
   logic [STATUS_WIDTH-1:0] flags_q, flags_d;
   logic                    accept;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         reload_q <= 1'b0;
         store_q  <= 1'b0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         reload_q <= reload_d;
         store_q  <= store_d;
         flags_q  <= flags_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      reload_d = reload_q;
      store_d  = store_q;
      flags_d  = flags_q;
      accept   = 1'b0;
      case (state_q)
         S_IDLE:  accept = start_i;
         S_LOAD:  state_d = S_EXEC;
         S_EXEC: begin
            flags_d = alu_status_i;
            state_d = store_q ? S_STORE : S_DONE;
         end
         S_STORE: state_d = S_DONE;
         S_DONE: begin
            state_d = S_IDLE;
`ifdef ACC_SEQ_B2B_EN
            accept  = start_i;
`endif
         end
         default: state_d = S_IDLE;
      endcase
      // Branch on the live inputs at acceptance; the captured copies drive later phases.
      if (accept) begin
         op_d     = op_i;
         reload_d = reload_i;
         store_d  = store_i;
         state_d  = reload_i ? S_LOAD : S_EXEC;
      end
   end

   always_comb begin
      busy_o          = (state_q != S_IDLE);
      done_o          = 1'b0;
      src_oe_o        = 1'b0;
      acc_cs_o        = 1'b0;
      acc_we_o        = 1'b0;
      acc_oe_o        = 1'b0;
      acc_opcode_le_o = 1'b0;
      acc_opcode_o    = LD_OPCODE;
      case (state_q)
         S_LOAD: begin
            // reload_q is always set here; qualifying ties the bus write to the captured request.
            src_oe_o = reload_q;
            acc_cs_o = reload_q;
            acc_we_o = reload_q;
         end
         S_EXEC: begin
            acc_opcode_le_o = 1'b1;
            acc_opcode_o    = op_q;
         end
         S_STORE: begin
            acc_cs_o = 1'b1;
            acc_oe_o = 1'b1;
         end
         S_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   assign flags_o = flags_q;

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: stimulus pushes the expected per-cycle output trace,
// a negedge monitor pops and compares whenever entries are pending.
module tb_acc_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [4:0] op;
   logic       reload, store;
   logic [3:0] alu_status;
   logic       busy, done, src_oe, acc_cs, acc_we, acc_oe, acc_opcode_le;
   logic [4:0] acc_opcode;
   logic [3:0] flags;

   acc_sequencer dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .op_i(op),
      .reload_i(reload), .store_i(store), .alu_status_i(alu_status),
      .busy_o(busy), .done_o(done), .src_oe_o(src_oe), .acc_cs_o(acc_cs),
      .acc_we_o(acc_we), .acc_oe_o(acc_oe), .acc_opcode_le_o(acc_opcode_le),
      .acc_opcode_o(acc_opcode), .flags_o(flags)
   );

   always #5 clk = ~clk;

   logic [15:0] exp_q[$];
   logic [3:0]  mflags;
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // {busy,done,src_oe,cs,we,oe,opcode_le,acc_opcode[4:0],flags[3:0]}
   function automatic logic [15:0] mk(input logic b, d, s, cs, we, oe, le,
                                      input logic [4:0] opc, input logic [3:0] fl);
      return {b, d, s, cs, we, oe, le, opc, fl};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e, a;
         e = exp_q.pop_front();
         a = {busy, done, src_oe, acc_cs, acc_we, acc_oe, acc_opcode_le, acc_opcode, flags};
         n_chk++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL trace cyc=%0d got b%0b d%0b s%0b cs%0b we%0b oe%0b le%0b opc=%h fl=%h want b%0b d%0b s%0b cs%0b we%0b oe%0b le%0b opc=%h fl=%h",
                     cyc, a[15], a[14], a[13], a[12], a[11], a[10], a[9], a[8:4], a[3:0],
                     e[15], e[14], e[13], e[12], e[11], e[10], e[9], e[8:4], e[3:0]);
         end
      end
   end

   task automatic idle_chk(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'h00, mflags));
         @(posedge clk); #1;
      end
   endtask

   // Entered and left at posedge+1; drop=1 holds start with op=2 through LOAD/EXEC.
   task automatic issue(input logic [4:0] o, input logic rl, input logic st,
                        input logic [3:0] stat, input bit drop);
      int n;
      n = 2 + int'(rl) + int'(st);
      start = 1'b1; op = o; reload = rl; store = st; alu_status = stat;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'h00, mflags));
      if (rl) exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 5'h00, mflags));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, o, mflags));
      mflags = stat;
      if (st) exp_q.push_back(mk(1, 0, 0, 1, 0, 1, 0, 5'h00, mflags));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'h00, mflags));
      @(posedge clk); #1;
      for (int k = 1; k <= n; k++) begin
         start = drop && (k <= 2);
         if (drop) op = 5'h02;
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic mid_reset();
      start = 1'b1; op = 5'h09; reload = 1'b1; store = 1'b1; alu_status = 4'hF;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'h00, mflags));
      @(posedge clk); #1;
      start = 1'b0;
      exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 5'h00, mflags));
      @(posedge clk); #2;
      // In EXEC now; reset with no clock edge before the next sample.
      reset = 1'b1;
      mflags = 4'h0;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'h00, 4'h0));
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = '0; reload = 1'b0; store = 1'b0; alu_status = '0;
      mflags = 4'h0;
      @(posedge clk); #1;
      idle_chk(2);
      reset = 1'b0;
      idle_chk(5);

      issue(5'h03, 1'b1, 1'b1, 4'b1010, 1'b0);  // full: done 4 cycles after accept
      issue(5'h07, 1'b0, 1'b0, 4'h5, 1'b0);     // skip both: done after 2
      issue(5'h1F, 1'b0, 1'b1, 4'hC, 1'b0);     // exec+store: done after 3
      issue(5'h01, 1'b1, 1'b0, 4'h6, 1'b1);     // start held while busy is dropped
      idle_chk(3);
      mid_reset();
      idle_chk(2);
      issue(5'h11, 1'b1, 1'b1, 4'h9, 1'b0);     // normal run after mid-op reset
      idle_chk(1);

`ifdef ACC_SEQ_B2B_EN
      // start held through DONE: second LOAD follows DONE directly.
      start = 1'b1; op = 5'h04; reload = 1'b1; store = 1'b0; alu_status = 4'h5;
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 5'h00, mflags));
      exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 5'h00, mflags));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 5'h04, mflags));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'h00, 4'h5));
      exp_q.push_back(mk(1, 0, 1, 1, 1, 0, 0, 5'h00, 4'h5));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 5'h06, 4'h5));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 5'h00, 4'h3));
      mflags = 4'h3;
      @(posedge clk); #1;
      op = 5'h06;
      @(posedge clk); #1;
      @(posedge clk); #1;
      alu_status = 4'h3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      idle_chk(2);
`endif

      for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      @(posedge clk); #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
